pkt_rx_parser: RTL

Ingress-side packet parser for the simple switch. It consumes the serial byte stream framed as `SOF (0xFF)`, `ADDR`, `PAYLOAD…`, `DELIMITER (0x55)`. It strips SOF and ADDR and writes the payload, delimiter included, into the port FIFO write interface. This is the format the egress FSM reads back out, so egress reads until it sees 0x55. Malformed traffic is handled without ever leaving an unterminated packet in the FIFO: FIFO overflow and over-length packets are truncated, terminated and counted.

---
 rtl/pkt_rx_parser.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pkt_rx_parser.sv
// Ingress packet parser: strips SOF/ADDR and pushes payload plus delimiter
// into the port FIFO, truncating and terminating malformed packets.
module pkt_rx_parser #(
  parameter int                  W_WIDTH   = 8,
  parameter logic [W_WIDTH-1:0]  SOF_BYTE  = 'hFF,
  parameter logic [W_WIDTH-1:0]  DELIMITER = 'h55,
  parameter int                  MAX_LEN   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_WIDTH-1:0] data_in,
  input  logic               data_valid,
  input  logic               fifo_full,
  output logic               wr_en,
  output logic [W_WIDTH-1:0] wr_data,
  output logic [W_WIDTH-1:0] pkt_addr,
  output logic               addr_valid,
  output logic               pkt_done,
  output logic               pkt_err,
  output logic [15:0]        pkt_cnt,
  output logic [7:0]         err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    PAYLOAD,
    DROP,
    TERM
  } state_t;

  localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

  state_t     state;
  logic [7:0] len;
  logic       term_pend;

  logic       is_delim;
  logic [7:0] err_next;

  // delimiter detect and saturating error increment
  assign is_delim = (data_in == DELIMITER);
  assign err_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  // parser FSM with registered FIFO write port and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= 8'd0;
      term_pend  <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      pkt_addr   <= '0;
      addr_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_cnt    <= 16'd0;
      err_cnt    <= 8'd0;
    end else begin
      wr_en      <= 1'b0;
      addr_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid && data_in == SOF_BYTE)
            state <= GET_ADDR;
        end
        GET_ADDR: begin
          if (data_valid) begin
            pkt_addr   <= data_in;
            addr_valid <= 1'b1;
            len        <= 8'd0;
            state      <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (data_valid) begin
            if (fifo_full) begin
              term_pend <= 1'b1;
              state     <= DROP;
            end else if (is_delim) begin
              wr_en    <= 1'b1;
              wr_data  <= data_in;
              pkt_done <= 1'b1;
              pkt_cnt  <= pkt_cnt + 16'd1;
              state    <= IDLE;
            end else if (len == LEN_LAST) begin
              // out of room: close the packet now, drop the rest
              wr_en     <= 1'b1;
              wr_data   <= DELIMITER;
              term_pend <= 1'b0;
              state     <= DROP;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= data_in;
              len     <= len + 8'd1;
            end
          end
        end
        DROP: begin
          if (data_valid && is_delim) begin
            if (term_pend && fifo_full) begin
              // error is flagged with the terminating write in TERM
              state <= TERM;
            end else begin
              if (term_pend) begin
                wr_en   <= 1'b1;
                wr_data <= DELIMITER;
              end
              pkt_err   <= 1'b1;
              err_cnt   <= err_next;
              term_pend <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        TERM: begin
          if (!fifo_full) begin
            wr_en     <= 1'b1;
            wr_data   <= DELIMITER;
            pkt_err   <= 1'b1;
            err_cnt   <= err_next;
            term_pend <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
